// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between an instruction reader and a data reader/writer
//
// Ports:
//   clk, rst                      clock and synchronous active-low reset
//   ARADDR_IM/ARVALID_IM/ARREADY_IM      instruction-side read request
//   RDATA_IM/RVALID_IM/RREADY_IM         instruction-side read response
//   ARADDR_DM/ARVALID_DM/ARREADY_DM      data-side read request
//   RDATA_DM/RVALID_DM/RREADY_DM         data-side read response
//   AWADDR_DM/AWVALID_DM/AWREADY_DM,
//   WDATA_DM/WSTRB_DM/WVALID_DM/WREADY_DM data-side write
//   ARADDR_S/ARVALID_S/ARREADY_S         shared memory read address
//   RDATA_S/RVALID_S/RREADY_S            shared memory read data
//   AWADDR_S/AWVALID_S/AWREADY_S,
//   WDATA_S/WSTRB_S/WVALID_S/WREADY_S    shared memory write
//
// Every output is a flop; requests are only looked at in IDLE, so a
// transaction in flight is never disturbed by new requests.

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   ARADDR_IM,
    input  logic                ARVALID_IM,
    output logic                ARREADY_IM,
    output logic [DATA_W-1:0]   RDATA_IM,
    output logic                RVALID_IM,
    input  logic                RREADY_IM,

    input  logic [ADDR_W-1:0]   ARADDR_DM,
    input  logic                ARVALID_DM,
    output logic                ARREADY_DM,
    output logic [DATA_W-1:0]   RDATA_DM,
    output logic                RVALID_DM,
    input  logic                RREADY_DM,

    input  logic [ADDR_W-1:0]   AWADDR_DM,
    input  logic                AWVALID_DM,
    output logic                AWREADY_DM,
    input  logic [DATA_W-1:0]   WDATA_DM,
    input  logic [DATA_W/8-1:0] WSTRB_DM,
    input  logic                WVALID_DM,
    output logic                WREADY_DM,

    output logic [ADDR_W-1:0]   ARADDR_S,
    output logic                ARVALID_S,
    input  logic                ARREADY_S,
    input  logic [DATA_W-1:0]   RDATA_S,
    input  logic                RVALID_S,
    output logic                RREADY_S,

    output logic [ADDR_W-1:0]   AWADDR_S,
    output logic                AWVALID_S,
    input  logic                AWREADY_S,
    output logic [DATA_W-1:0]   WDATA_S,
    output logic [DATA_W/8-1:0] WSTRB_S,
    output logic                WVALID_S,
    input  logic                WREADY_S
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        RESP,
        W
    } state_t;

    localparam logic GNT_IM = 1'b0;
    localparam logic GNT_DM = 1'b1;

    state_t state;
    logic   last_grant;   // master that won the previous grant
    logic   gnt_dm;       // owner of the transaction in flight
    logic   aw_done;      // write address handshake already completed
    logic   w_done;       // write data handshake already completed

    logic im_req;
    logic dm_wr;
    logic dm_rd;
    logic dm_req;
    logic pick_dm;
    logic aw_ok;
    logic w_ok;

    // Request decode. These nets only feed flops, so outputs stay registered.
    always_comb begin
        im_req  = ARVALID_IM;
        dm_wr   = AWVALID_DM & WVALID_DM;
        dm_rd   = ARVALID_DM & ~dm_wr;      // a data-side write beats its own read
        dm_req  = dm_wr | dm_rd;
        // DM wins when alone, or on contention when IM had the last grant.
        pick_dm = dm_req & (~im_req | (last_grant == GNT_IM));
        // A channel is finished when it already completed or completes this cycle.
        aw_ok   = aw_done | (AWVALID_S & AWREADY_S);
        w_ok    = w_done  | (WVALID_S  & WREADY_S);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_DM;   // so the first contended grant goes to IM
            gnt_dm     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ARREADY_IM <= 1'b0;
            ARREADY_DM <= 1'b0;
            AWREADY_DM <= 1'b0;
            WREADY_DM  <= 1'b0;
            RDATA_IM   <= '0;
            RVALID_IM  <= 1'b0;
            RDATA_DM   <= '0;
            RVALID_DM  <= 1'b0;
            ARADDR_S   <= '0;
            ARVALID_S  <= 1'b0;
            RREADY_S   <= 1'b0;
            AWADDR_S   <= '0;
            AWVALID_S  <= 1'b0;
            WDATA_S    <= '0;
            WSTRB_S    <= '0;
            WVALID_S   <= 1'b0;
        end else begin
            // Master-side readies are single-cycle acceptance pulses.
            ARREADY_IM <= 1'b0;
            ARREADY_DM <= 1'b0;
            AWREADY_DM <= 1'b0;
            WREADY_DM  <= 1'b0;

            case (state)
                IDLE: begin
                    if (im_req | dm_req) begin
                        last_grant <= pick_dm;
                        gnt_dm     <= pick_dm;
                        if (pick_dm && dm_wr) begin
                            AWADDR_S   <= AWADDR_DM;
                            WDATA_S    <= WDATA_DM;
                            WSTRB_S    <= WSTRB_DM;
                            AWREADY_DM <= 1'b1;
                            WREADY_DM  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                            state      <= W;
                        end else if (pick_dm) begin
                            ARADDR_S   <= ARADDR_DM;
                            ARREADY_DM <= 1'b1;
                            state      <= AR;
                        end else begin
                            ARADDR_S   <= ARADDR_IM;
                            ARREADY_IM <= 1'b1;
                            state      <= AR;
                        end
                    end
                end

                AR: begin
                    // First cycle in AR raises ARVALID_S; it then waits for the slave.
                    if (!ARVALID_S) begin
                        ARVALID_S <= 1'b1;
                    end else if (ARREADY_S) begin
                        ARVALID_S <= 1'b0;
                        RREADY_S  <= 1'b1;
                        state     <= R;
                    end
                end

                R: begin
                    if (RVALID_S) begin
                        RREADY_S <= 1'b0;
                        if (gnt_dm) begin
                            RDATA_DM  <= RDATA_S;
                            RVALID_DM <= 1'b1;
                        end else begin
                            RDATA_IM  <= RDATA_S;
                            RVALID_IM <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    // Data registers are untouched here, so the response holds stable.
                    if ((gnt_dm && RREADY_DM) || (!gnt_dm && RREADY_IM)) begin
                        RVALID_IM <= 1'b0;
                        RVALID_DM <= 1'b0;
                        state     <= IDLE;
                    end
                end

                W: begin
                    // Both channels rise together on the first W cycle and then
                    // retire independently on their own ready.
                    if (!aw_done) begin
                        if (!AWVALID_S) begin
                            AWVALID_S <= 1'b1;
                        end else if (AWREADY_S) begin
                            AWVALID_S <= 1'b0;
                            aw_done   <= 1'b1;
                        end
                    end
                    if (!w_done) begin
                        if (!WVALID_S) begin
                            WVALID_S <= 1'b1;
                        end else if (WREADY_S) begin
                            WVALID_S <= 1'b0;
                            w_done   <= 1'b1;
                        end
                    end
                    if (aw_ok && w_ok) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter

module tb_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ARADDR_IM;
    logic          ARVALID_IM;
    logic          ARREADY_IM;
    logic [127:0]  RDATA_IM;
    logic          RVALID_IM;
    logic          RREADY_IM;
    logic [31:0]   ARADDR_DM;
    logic          ARVALID_DM;
    logic          ARREADY_DM;
    logic [127:0]  RDATA_DM;
    logic          RVALID_DM;
    logic          RREADY_DM;
    logic [31:0]   AWADDR_DM;
    logic          AWVALID_DM;
    logic          AWREADY_DM;
    logic [127:0]  WDATA_DM;
    logic [15:0]   WSTRB_DM;
    logic          WVALID_DM;
    logic          WREADY_DM;
    logic [31:0]   ARADDR_S;
    logic          ARVALID_S;
    logic          ARREADY_S;
    logic [127:0]  RDATA_S;
    logic          RVALID_S;
    logic          RREADY_S;
    logic [31:0]   AWADDR_S;
    logic          AWVALID_S;
    logic          AWREADY_S;
    logic [127:0]  WDATA_S;
    logic [15:0]   WSTRB_S;
    logic          WVALID_S;
    logic          WREADY_S;

    mem_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
        .clk(clk), .rst(rst),
        .ARADDR_IM(ARADDR_IM), .ARVALID_IM(ARVALID_IM), .ARREADY_IM(ARREADY_IM),
        .RDATA_IM(RDATA_IM), .RVALID_IM(RVALID_IM), .RREADY_IM(RREADY_IM),
        .ARADDR_DM(ARADDR_DM), .ARVALID_DM(ARVALID_DM), .ARREADY_DM(ARREADY_DM),
        .RDATA_DM(RDATA_DM), .RVALID_DM(RVALID_DM), .RREADY_DM(RREADY_DM),
        .AWADDR_DM(AWADDR_DM), .AWVALID_DM(AWVALID_DM), .AWREADY_DM(AWREADY_DM),
        .WDATA_DM(WDATA_DM), .WSTRB_DM(WSTRB_DM), .WVALID_DM(WVALID_DM), .WREADY_DM(WREADY_DM),
        .ARADDR_S(ARADDR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RDATA_S(RDATA_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWADDR_S(AWADDR_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         dm;
        logic [127:0] data;
    } rd_t;

    rd_t          exp_rd[$];
    rd_t          got_rd[$];
    logic         grant_log[$];
    logic [31:0]  aw_q[$];
    logic [143:0] w_q[$];

    int           n_checks = 0;
    int           n_fail   = 0;
    int           both_rv  = 0;
    logic         im_auto  = 1'b0;
    logic         dm_auto  = 1'b0;
    logic         force_en = 1'b0;
    logic [127:0] rdata_force = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    logic [31:0]  last_ar;

    function automatic logic [127:0] model(input logic [31:0] a);
        return {a ^ 32'hA5A5A5A5, ~a, a + 32'h00001234, a};
    endfunction

    function automatic logic [127:0] exp_data(input logic [31:0] a);
        return force_en ? rdata_force : model(a);
    endfunction

    // Slave memory: always ready, read data derived from the last accepted address.
    assign RDATA_S = force_en ? rdata_force : model(last_ar);

    always @(posedge clk) begin
        if (ARVALID_S && ARREADY_S) last_ar <= ARADDR_S;
        if (AWVALID_S && AWREADY_S) aw_q.push_back(AWADDR_S);
        if (WVALID_S && WREADY_S)   w_q.push_back({WSTRB_S, WDATA_S});
    end

    // Log the handshakes finishing in the current cycle, update master
    // requests for the next one, then advance to 1 ns after the next edge.
    task automatic step();
        if (RVALID_IM && RVALID_DM) both_rv++;
        if (ARVALID_IM && ARREADY_IM) begin
            exp_rd.push_back('{dm: 1'b0, data: exp_data(ARADDR_IM)});
            grant_log.push_back(1'b0);
            if (im_auto) ARADDR_IM = ARADDR_IM + 32'h10;
            else         ARVALID_IM = 1'b0;
        end
        if (ARVALID_DM && ARREADY_DM) begin
            exp_rd.push_back('{dm: 1'b1, data: exp_data(ARADDR_DM)});
            grant_log.push_back(1'b1);
            if (dm_auto) ARADDR_DM = ARADDR_DM + 32'h10;
            else         ARVALID_DM = 1'b0;
        end
        if (AWVALID_DM && AWREADY_DM) begin
            grant_log.push_back(1'b1);
            AWVALID_DM = 1'b0;
            WVALID_DM  = 1'b0;
        end
        if (RVALID_IM && RREADY_IM) got_rd.push_back('{dm: 1'b0, data: RDATA_IM});
        if (RVALID_DM && RREADY_DM) got_rd.push_back('{dm: 1'b1, data: RDATA_DM});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst = 1'b0;
        ARVALID_IM = 1'b1; ARADDR_IM = 32'h44;
        repeat (3) step();
        outs = {ARREADY_IM, ARREADY_DM, AWREADY_DM, WREADY_DM, RVALID_IM, RVALID_DM,
                ARVALID_S, RREADY_S, AWVALID_S, WVALID_S};
        n_checks++;
        if (outs !== 10'b0) begin n_fail++; $display("FAIL reset_handshakes got %b want 0", outs); end
        n_checks++;
        if ({ARADDR_S, AWADDR_S, WSTRB_S} !== 80'b0) begin
            n_fail++; $display("FAIL reset_addr got %h %h %h want 0", ARADDR_S, AWADDR_S, WSTRB_S);
        end
        n_checks++;
        if ({WDATA_S, RDATA_IM, RDATA_DM} !== 384'b0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h want 0", WDATA_S, RDATA_IM, RDATA_DM);
        end
        ARVALID_IM = 1'b0;
        rst = 1'b1;
        step();
        outs = {ARREADY_IM, ARREADY_DM, AWREADY_DM, WREADY_DM, RVALID_IM, RVALID_DM,
                ARVALID_S, RREADY_S, AWVALID_S, WVALID_S};
        n_checks++;
        if (outs !== 10'b0) begin n_fail++; $display("FAIL idle_after_reset got %b want 0", outs); end
    endtask

    task automatic test_im_read();
        rd_t g, e;
        force_en = 1'b1;
        exp_rd.delete(); got_rd.delete();
        ARADDR_IM = 32'h10; ARVALID_IM = 1'b1;
        step();
        n_checks++;
        if ({ARREADY_IM, ARREADY_DM} !== 2'b10) begin
            n_fail++; $display("FAIL im_accept got %b want 10", {ARREADY_IM, ARREADY_DM});
        end
        step();
        n_checks++;
        if (ARVALID_S !== 1'b1 || ARADDR_S !== 32'h10) begin
            n_fail++; $display("FAIL im_arvalid got %b %h want 1 00000010", ARVALID_S, ARADDR_S);
        end
        step();
        n_checks++;
        if ({RREADY_S, ARVALID_S} !== 2'b10) begin
            n_fail++; $display("FAIL im_rready got %b want 10", {RREADY_S, ARVALID_S});
        end
        step();
        n_checks++;
        if (RVALID_IM !== 1'b1 || RVALID_DM !== 1'b0 || RDATA_IM !== rdata_force) begin
            n_fail++; $display("FAIL im_rvalid got %b %b %h want 1 0 %h", RVALID_IM, RVALID_DM, RDATA_IM, rdata_force);
        end
        repeat (3) step();
        n_checks++;
        if (RVALID_IM !== 1'b0) begin n_fail++; $display("FAIL im_rvalid_drop got %b want 0", RVALID_IM); end
        while (got_rd.size() > 0) begin
            g = got_rd.pop_front();
            n_checks++;
            if (exp_rd.size() == 0) begin n_fail++; $display("FAIL im_rd_extra got %h want none", g.data); end
            else begin
                e = exp_rd.pop_front();
                if (g.dm !== e.dm || g.data !== e.data) begin
                    n_fail++; $display("FAIL im_rd got %b %h want %b %h", g.dm, g.data, e.dm, e.data);
                end
            end
        end
        n_checks++;
        if (exp_rd.size() != 0) begin n_fail++; $display("FAIL im_rd_missing got %0d left want 0", exp_rd.size()); end
        force_en = 1'b0;
    endtask

    task automatic test_round_robin();
        rd_t g, e;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        exp_rd.delete(); got_rd.delete(); grant_log.delete();
        both_rv = 0;
        ARADDR_IM = 32'h0000; ARADDR_DM = 32'h1000;
        ARVALID_IM = 1'b1; ARVALID_DM = 1'b1;
        im_auto = 1'b1; dm_auto = 1'b1;
        repeat (40) step();
        im_auto = 1'b0; dm_auto = 1'b0;
        repeat (25) step();
        n_checks++;
        if (grant_log.size() < 8) begin n_fail++; $display("FAIL rr_count got %0d want >=8", grant_log.size()); end
        for (int i = 0; i < grant_log.size(); i++) begin
            logic want;
            want = (i % 2 == 1);
            n_checks++;
            if (grant_log[i] !== want) begin
                n_fail++; $display("FAIL rr_order[%0d] got %b want %b", i, grant_log[i], want);
            end
        end
        while (got_rd.size() > 0) begin
            g = got_rd.pop_front();
            n_checks++;
            if (exp_rd.size() == 0) begin n_fail++; $display("FAIL rr_rd_extra got %h want none", g.data); end
            else begin
                e = exp_rd.pop_front();
                if (g.dm !== e.dm || g.data !== e.data) begin
                    n_fail++; $display("FAIL rr_rd got %b %h want %b %h", g.dm, g.data, e.dm, e.data);
                end
            end
        end
        n_checks++;
        if (exp_rd.size() != 0) begin n_fail++; $display("FAIL rr_rd_missing got %0d left want 0", exp_rd.size()); end
        n_checks++;
        if (both_rv != 0) begin n_fail++; $display("FAIL rr_both_rvalid got %0d want 0", both_rv); end
    endtask

    task automatic test_write_priority();
        rd_t  g, e;
        logic early_rd;
        exp_rd.delete(); got_rd.delete(); aw_q.delete(); w_q.delete();
        AWADDR_DM = 32'h200; WDATA_DM = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        WSTRB_DM = 16'h00FF; AWVALID_DM = 1'b1; WVALID_DM = 1'b1;
        ARADDR_DM = 32'h300; ARVALID_DM = 1'b1;
        AWREADY_S = 1'b0; WREADY_S = 1'b1;
        step();
        n_checks++;
        if ({AWREADY_DM, WREADY_DM, ARREADY_DM} !== 3'b110) begin
            n_fail++; $display("FAIL wr_accept got %b want 110", {AWREADY_DM, WREADY_DM, ARREADY_DM});
        end
        early_rd = ARREADY_DM;
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S} !== 2'b11) begin n_fail++; $display("FAIL wr_t1 got %b want 11", {AWVALID_S, WVALID_S}); end
        early_rd = early_rd | ARREADY_DM;
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S} !== 2'b10) begin n_fail++; $display("FAIL wr_t2 got %b want 10", {AWVALID_S, WVALID_S}); end
        early_rd = early_rd | ARREADY_DM;
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S} !== 2'b10) begin n_fail++; $display("FAIL wr_t3 got %b want 10", {AWVALID_S, WVALID_S}); end
        early_rd = early_rd | ARREADY_DM;
        AWREADY_S = 1'b1;
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S, ARREADY_DM} !== 3'b000) begin
            n_fail++; $display("FAIL wr_t4 got %b want 000", {AWVALID_S, WVALID_S, ARREADY_DM});
        end
        n_checks++;
        if (early_rd !== 1'b0) begin n_fail++; $display("FAIL wr_read_during_write got %b want 0", early_rd); end
        step();
        n_checks++;
        if (ARREADY_DM !== 1'b1) begin n_fail++; $display("FAIL wr_then_read got %b want 1", ARREADY_DM); end
        repeat (8) step();
        n_checks++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h200) begin
            n_fail++; $display("FAIL wr_awaddr got %0d entries want 1 at 00000200", aw_q.size());
        end
        n_checks++;
        if (w_q.size() != 1 || w_q[0] !== {16'h00FF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}) begin
            n_fail++; $display("FAIL wr_wdata got %0d entries want 1 matching", w_q.size());
        end
        while (got_rd.size() > 0) begin
            g = got_rd.pop_front();
            n_checks++;
            if (exp_rd.size() == 0) begin n_fail++; $display("FAIL wr_rd_extra got %h want none", g.data); end
            else begin
                e = exp_rd.pop_front();
                if (g.dm !== e.dm || g.data !== e.data) begin
                    n_fail++; $display("FAIL wr_rd got %b %h want %b %h", g.dm, g.data, e.dm, e.data);
                end
            end
        end
        n_checks++;
        if (exp_rd.size() != 0) begin n_fail++; $display("FAIL wr_rd_missing got %0d left want 0", exp_rd.size()); end

        // Fast write: both slave readies high, handshakes finish together.
        aw_q.delete(); w_q.delete();
        AWADDR_DM = 32'h210; WDATA_DM = 128'hCAFE; WSTRB_DM = 16'hF00F;
        AWVALID_DM = 1'b1; WVALID_DM = 1'b1;
        step();
        n_checks++;
        if ({AWREADY_DM, WREADY_DM} !== 2'b11) begin n_fail++; $display("FAIL fw_accept got %b want 11", {AWREADY_DM, WREADY_DM}); end
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S} !== 2'b11 || AWADDR_S !== 32'h210) begin
            n_fail++; $display("FAIL fw_t1 got %b %h want 11 00000210", {AWVALID_S, WVALID_S}, AWADDR_S);
        end
        step();
        n_checks++;
        if ({AWVALID_S, WVALID_S} !== 2'b00 || aw_q.size() != 1 || w_q.size() != 1) begin
            n_fail++; $display("FAIL fw_t2 got %b %0d %0d want 00 1 1", {AWVALID_S, WVALID_S}, aw_q.size(), w_q.size());
        end
        n_checks++;
        if (w_q.size() == 1 && w_q[0] !== {16'hF00F, 128'hCAFE}) begin
            n_fail++; $display("FAIL fw_wdata got %h want %h", w_q[0], {16'hF00F, 128'hCAFE});
        end
    endtask

    task automatic test_rready_stall();
        rd_t g, e;
        exp_rd.delete(); got_rd.delete();
        RREADY_IM = 1'b0;
        ARADDR_IM = 32'h40; ARVALID_IM = 1'b1;
        ARADDR_DM = 32'h80; ARVALID_DM = 1'b1;
        for (int i = 0; i < 10 && RVALID_IM !== 1'b1; i++) step();
        n_checks++;
        if (RVALID_IM !== 1'b1) begin n_fail++; $display("FAIL stall_timeout got %b want 1", RVALID_IM); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (RVALID_IM !== 1'b1 || RDATA_IM !== model(32'h40) || ARVALID_S !== 1'b0 || ARREADY_DM !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got %b %h %b %b want 1 %h 0 0", i, RVALID_IM, RDATA_IM, ARVALID_S, ARREADY_DM, model(32'h40));
            end
        end
        RREADY_IM = 1'b1;
        repeat (12) step();
        while (got_rd.size() > 0) begin
            g = got_rd.pop_front();
            n_checks++;
            if (exp_rd.size() == 0) begin n_fail++; $display("FAIL stall_rd_extra got %h want none", g.data); end
            else begin
                e = exp_rd.pop_front();
                if (g.dm !== e.dm || g.data !== e.data) begin
                    n_fail++; $display("FAIL stall_rd got %b %h want %b %h", g.dm, g.data, e.dm, e.data);
                end
            end
        end
        n_checks++;
        if (exp_rd.size() != 0) begin n_fail++; $display("FAIL stall_rd_missing got %0d left want 0", exp_rd.size()); end
    endtask

    task automatic test_reset_mid_txn();
        rd_t        g, e;
        logic [9:0] outs;
        ARADDR_IM = 32'h500; ARVALID_IM = 1'b1;
        for (int i = 0; i < 8 && RREADY_S !== 1'b1; i++) step();
        n_checks++;
        if (RREADY_S !== 1'b1) begin n_fail++; $display("FAIL mid_reach_r got %b want 1", RREADY_S); end
        // The read in flight is abandoned; nothing of it may come back.
        exp_rd.delete(); got_rd.delete();
        rst = 1'b0;
        ARADDR_IM = 32'h700; ARVALID_IM = 1'b1;
        ARADDR_DM = 32'h600; ARVALID_DM = 1'b1;
        step();
        outs = {ARREADY_IM, ARREADY_DM, AWREADY_DM, WREADY_DM, RVALID_IM, RVALID_DM,
                ARVALID_S, RREADY_S, AWVALID_S, WVALID_S};
        n_checks++;
        if (outs !== 10'b0) begin n_fail++; $display("FAIL mid_reset_outs got %b want 0", outs); end
        rst = 1'b1;
        step();
        n_checks++;
        if ({ARREADY_IM, ARREADY_DM} !== 2'b10) begin
            n_fail++; $display("FAIL mid_first_grant got %b want 10", {ARREADY_IM, ARREADY_DM});
        end
        repeat (20) step();
        n_checks++;
        if (got_rd.size() != 2) begin n_fail++; $display("FAIL mid_resp_count got %0d want 2", got_rd.size()); end
        while (got_rd.size() > 0) begin
            g = got_rd.pop_front();
            n_checks++;
            if (exp_rd.size() == 0) begin n_fail++; $display("FAIL mid_rd_extra got %h want none", g.data); end
            else begin
                e = exp_rd.pop_front();
                if (g.dm !== e.dm || g.data !== e.data) begin
                    n_fail++; $display("FAIL mid_rd got %b %h want %b %h", g.dm, g.data, e.dm, e.data);
                end
            end
        end
        n_checks++;
        if (exp_rd.size() != 0) begin n_fail++; $display("FAIL mid_rd_missing got %0d left want 0", exp_rd.size()); end
    endtask

    initial begin
        rst = 1'b0;
        ARADDR_IM = '0; ARVALID_IM = 1'b0; RREADY_IM = 1'b1;
        ARADDR_DM = '0; ARVALID_DM = 1'b0; RREADY_DM = 1'b1;
        AWADDR_DM = '0; AWVALID_DM = 1'b0; WDATA_DM = '0; WSTRB_DM = '0; WVALID_DM = 1'b0;
        ARREADY_S = 1'b1; RVALID_S = 1'b1; AWREADY_S = 1'b1; WREADY_S = 1'b1;
        #1;
        test_reset();
        test_im_read();
        test_round_robin();
        test_write_priority();
        test_rready_stall();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
